// File: rtl/fft_bfly_sched.sv
// Radix-2 DIF butterfly address sequencer.
// Issues X/Y read addresses and twiddle index per butterfly, then the
// matching write-back pair PIPE_LAT non-stalled cycles later.
// Optional macro FFT_SCHED_BITREV_OUT_EN adds a bit-reversed unload pass.
module fft_bfly_sched #(
  parameter int unsigned N_LOG2   = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_LOG2)-1:0]   stage,
  output logic                        rd_en,
  output logic [N_LOG2-1:0]           rd_addr_x,
  output logic [N_LOG2-1:0]           rd_addr_y,
  output logic [N_LOG2-2:0]           tw_idx,
  output logic                        wr_en,
  output logic [N_LOG2-1:0]           wr_addr_x,
  output logic [N_LOG2-1:0]           wr_addr_y,
  output logic                        out_valid,
  output logic [N_LOG2-1:0]           out_addr
);

  localparam int unsigned SW = $clog2(N_LOG2);
  localparam int unsigned BW = N_LOG2 - 1;
  localparam int unsigned DW = $clog2(PIPE_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
`ifdef FFT_SCHED_BITREV_OUT_EN
    UNLOAD,
`endif
    DONE
  } state_t;

  typedef struct packed {
    logic              v;
    logic [N_LOG2-1:0] x;
    logic [N_LOG2-1:0] y;
  } wr_t;

  state_t            state, state_n;
  logic [SW-1:0]     s, s_n;
  logic [BW-1:0]     b, b_n;
  logic [DW-1:0]     d, d_n;
  logic              issue;

  logic [N_LOG2-1:0] bx, span_v, mask, pos_v, ax, ay;
  logic [BW-1:0]     tw;

  wr_t               pipe [PIPE_LAT];

`ifdef FFT_SCHED_BITREV_OUT_EN
  logic [N_LOG2-1:0] u, u_n;
  logic              oissue;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction
`endif

  // Butterfly addressing: X is b with a 0 inserted at bit (N_LOG2-1-s),
  // Y sets that bit; equals grp*2*span + pos and X + span.
  always_comb begin
    bx     = {1'b0, b};
    span_v = N_LOG2'(1) << (N_LOG2 - 1 - s);
    mask   = span_v - 1'b1;
    pos_v  = bx & mask;
    ax     = ((bx & ~mask) << 1) | pos_v;
    ay     = ax | span_v;
    tw     = BW'(pos_v << s);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      d     <= '0;
`ifdef FFT_SCHED_BITREV_OUT_EN
      u     <= '0;
`endif
    end else begin
      state <= state_n;
      s     <= s_n;
      b     <= b_n;
      d     <= d_n;
`ifdef FFT_SCHED_BITREV_OUT_EN
      u     <= u_n;
`endif
    end
  end

  // Next-state logic; stall freezes every counter except in IDLE/DONE.
  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    d_n     = d;
    issue   = 1'b0;
`ifdef FFT_SCHED_BITREV_OUT_EN
    u_n     = u;
    oissue  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          s_n     = '0;
          b_n     = '0;
          d_n     = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (b == '1) begin
            state_n = DRAIN;
            d_n     = '0;
          end else begin
            b_n = b + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (d == DW'(PIPE_LAT - 1)) begin
            d_n = '0;
            if (s == SW'(N_LOG2 - 1)) begin
`ifdef FFT_SCHED_BITREV_OUT_EN
              state_n = UNLOAD;
              u_n     = '0;
`else
              state_n = DONE;
`endif
            end else begin
              state_n = RUN;
              s_n     = s + 1'b1;
              b_n     = '0;
            end
          end else begin
            d_n = d + 1'b1;
          end
        end
      end
`ifdef FFT_SCHED_BITREV_OUT_EN
      UNLOAD: begin
        if (!stall) begin
          oissue = 1'b1;
          if (u == '1) state_n = DONE;
          else         u_n     = u + 1'b1;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered read/write strobes, addresses and the write-back delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_x <= '0;
      rd_addr_y <= '0;
      tw_idx    <= '0;
      wr_en     <= 1'b0;
      wr_addr_x <= '0;
      wr_addr_y <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (state == RUN || state == DRAIN) begin
        if (!stall) begin
          busy  <= 1'b1;
          stage <= s;
          rd_en <= issue;
          if (issue) begin
            rd_addr_x <= ax;
            rd_addr_y <= ay;
            tw_idx    <= tw;
          end
          // Idle slots carry the held read address so write addresses
          // track read addresses exactly PIPE_LAT active cycles later.
          pipe[0] <= issue ? wr_t'{1'b1, ax, ay} : wr_t'{1'b0, rd_addr_x, rd_addr_y};
          for (int unsigned i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
          wr_en     <= pipe[PIPE_LAT-1].v;
          wr_addr_x <= pipe[PIPE_LAT-1].x;
          wr_addr_y <= pipe[PIPE_LAT-1].y;
        end
      end else if (state == DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end else if (state == IDLE) begin
        busy <= 1'b0;
        for (int unsigned i = 0; i < PIPE_LAT; i++) pipe[i].v <= 1'b0;
      end
    end
  end

`ifdef FFT_SCHED_BITREV_OUT_EN
  // Unload strobe: natural-order readout via bit-reversed RAM address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else begin
      out_valid <= oissue;
      if (oissue) out_addr <= bitrev(u);
    end
  end
`else
  assign out_valid = 1'b0;
  assign out_addr  = '0;
`endif

endmodule
